shift_share_arbiter: RTL
========================

// Module: shift_share_arbiter
// PURPOSE
//  Shares one pipelined logical-left-shift unit among NUM_REQ dataflow requesters, each with its own
//  lhs/rhs/result valid-ready handshake. Round-robin arbitration picks one joined request per cycle.
//  A requester tag travels with the operands so each result returns to its own requester.
//  Sits between lowered shli/shrui-class ops in resource-sharing circuits and one physical shifter.
// PARAMETERS
//  BITWIDTH  32  operand/result width
//  NUM_REQ   4   number of requesters (>=2)
//  LATENCY   2   shifter pipeline depth in cycles (>=1)
// PORTS
//  clk           in   1                  clock, rising edge
//  rst           in   1                  reset, asynchronous, active-low
//  lhs           in   NUM_REQ*BITWIDTH   requester i operand at [i*BITWIDTH +: BITWIDTH]
//  lhs_valid     in   NUM_REQ            per-requester lhs valid
//  rhs           in   NUM_REQ*BITWIDTH   shift amounts, same packing
//  rhs_valid     in   NUM_REQ            per-requester rhs valid
//  result_ready  in   NUM_REQ            per-requester consumer ready
//  result        out  BITWIDTH           shared result bus (valid only where result_valid bit set)
//  result_valid  out  NUM_REQ            one-hot-or-zero result valid
//  lhs_ready     out  NUM_REQ            lhs accepted this cycle
//  rhs_ready     out  NUM_REQ            rhs accepted this cycle
// BEHAVIOUR
//  - Reset: pipe valids=0, rr pointer=0; result_valid, lhs_ready, rhs_ready all 0 while rst low and in the cycle after release.
//  - Requester i eligible iff lhs_valid[i] & rhs_valid[i] (join). The two halves are never accepted separately.
//  - Grant: first eligible index at or after rr_ptr, wrapping modulo NUM_REQ.
//  - stall = tail stage valid & !result_ready[tail_tag].
//  - Accept: lhs_ready[g] = rhs_ready[g] = 1 for granted g only, and only when !stall. All other ready bits are 0.
//  - On accept, rr_ptr <= (g+1) mod NUM_REQ. rr_ptr holds when nothing is accepted.
//  - Pipeline: LATENCY stages of {valid, tag, data}. Stage 0 captures lhs[g] << rhs[g]; later stages shift down.
//  - When stall is high the whole pipe freezes, bubbles included. When stall is low each stage advances every cycle.
//  - Latency: accept in cycle t -> result_valid[tag] high in cycle t+LATENCY if unstalled.
//  - Result stays stable until accepted: result_valid and result hold while stalled.
//  - Throughput: 1 op/cycle. Results are strictly in issue order.
//  - Arithmetic: logical left shift, zero fill. rhs treated as unsigned. rhs >= BITWIDTH -> result 0.
//  - Tail result_ready[tag] & valid in the same cycle as a new accept: both transfers happen in that cycle.
//  - Tail empty: no stall, regardless of result_ready.
//  - Asynchronous reset mid-operation discards all in-flight ops. No result is emitted for them.
// CONFIGURATION
//  SHIFT_SHARE_STATS_EN defined:
//  - Adds output stall_cycles [31:0]: counts cycles with stall high.
//  - Counter saturates at 32'hFFFF_FFFF and clears on reset.
//  SHIFT_SHARE_STATS_EN undefined: the port and the counter do not exist. Behaviour is otherwise identical.
// STRUCTURE
//  - Package shift_share_pkg holds: TAG_W = $clog2(NUM_REQ) (min 1); typedef stage_t {valid, tag, data}.
//  - Sub-module rr_arbiter #(N): inputs req[N], ptr; outputs gnt one-hot and gnt_idx. Purely combinational.
//  - Top holds: rr_ptr register, pipeline regs, tag->result_valid decode, optional stats counter.
// TESTING
//  1 Reset: rst low mid-stream with 2 ops in pipe -> all valid/ready 0; no results after release; rr_ptr=0.
//  2 Single op: req1 lhs=32'h1, rhs=4, LATENCY=2 -> ready[1] in cycle t; result=32'h10, result_valid=4'b0010 at t+2.
//  3 Fairness: all 4 valid continuously, all ready -> grant order 0,1,2,3,0,1... Each requester gets exactly 1 grant per 4 cycles.
//  4 Join: lhs_valid[2]=1, rhs_valid[2]=0 for 5 cycles -> never granted; grant only once rhs_valid[2]=1.
//  5 Backpressure: result_ready[0]=0 for 3 cycles with tail tag 0 -> pipe frozen, all ready 0, result held; resumes in order.
//  6 Width edge: lhs=32'hFFFF_FFFF with rhs=31 -> 32'h8000_0000; rhs=32 -> 0; rhs=32'hFFFF_FFFF -> 0. With STATS_EN, stall_cycles matches scenario 5 (=3).

Source files
------------

// File: rtl/shift_share_pkg.sv
// Shared types and helpers for the shift_share_arbiter block.
// stage_t describes one shifter pipeline stage in the default configuration.
package shift_share_pkg;

  localparam int BITWIDTH_DEF = 32;
  localparam int NUM_REQ_DEF  = 4;
  localparam int LATENCY_DEF  = 2;

  // Tag width is never allowed to collapse to zero bits.
  function automatic int tag_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int TAG_W = tag_width(NUM_REQ_DEF);

  typedef struct packed {
    logic                    valid;
    logic [TAG_W-1:0]        tag;
    logic [BITWIDTH_DEF-1:0] data;
  } stage_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N <= 2) ? 1 : $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic found;
  int   idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int off = 0; off < N; off++) begin
      idx = int'(ptr) + off;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/shift_share_arbiter.sv
// One pipelined left shifter shared by NUM_REQ joined lhs/rhs requesters, results tagged back.
// Define SHIFT_SHARE_STATS_EN to add the saturating stall_cycles counter output.
module shift_share_arbiter
  import shift_share_pkg::*;
#(
  parameter int BITWIDTH = BITWIDTH_DEF,
  parameter int NUM_REQ  = NUM_REQ_DEF,
  parameter int LATENCY  = LATENCY_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ*BITWIDTH-1:0] lhs,
  input  logic [NUM_REQ-1:0]          lhs_valid,
  input  logic [NUM_REQ*BITWIDTH-1:0] rhs,
  input  logic [NUM_REQ-1:0]          rhs_valid,
  input  logic [NUM_REQ-1:0]          result_ready,
  output logic [BITWIDTH-1:0]         result,
  output logic [NUM_REQ-1:0]          result_valid,
  output logic [NUM_REQ-1:0]          lhs_ready,
  output logic [NUM_REQ-1:0]          rhs_ready
`ifdef SHIFT_SHARE_STATS_EN
  ,
  output logic [31:0]                 stall_cycles
`endif
);

  localparam int TW = tag_width(NUM_REQ);

  typedef struct packed {
    logic                valid;
    logic [TW-1:0]       tag;
    logic [BITWIDTH-1:0] data;
  } pipe_stage_t;

  pipe_stage_t         pipe_q [LATENCY];
  pipe_stage_t         stage0_d;
  pipe_stage_t         tail;
  logic [TW-1:0]       rr_ptr_q, rr_ptr_d;
  logic                run_q;
  logic [NUM_REQ-1:0]  eligible, gnt;
  logic [TW-1:0]       gnt_idx;
  logic                stall, accept;
  logic [BITWIDTH-1:0] lhs_sel, rhs_sel;

  assign tail  = pipe_q[LATENCY-1];
  assign stall = tail.valid & ~result_ready[tail.tag];

  // run_q keeps every ready low for the first cycle after reset release.
  assign eligible = lhs_valid & rhs_valid & {NUM_REQ{run_q}};

  rr_arbiter #(.N(NUM_REQ), .IW(TW)) u_rr (
    .req     (eligible),
    .ptr     (rr_ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign accept    = ~stall & (|eligible);
  assign lhs_ready = accept ? gnt : '0;
  assign rhs_ready = accept ? gnt : '0;

  assign lhs_sel = lhs[int'(gnt_idx)*BITWIDTH +: BITWIDTH];
  assign rhs_sel = rhs[int'(gnt_idx)*BITWIDTH +: BITWIDTH];

  always_comb begin
    stage0_d.valid = accept;
    stage0_d.tag   = gnt_idx;
    stage0_d.data  = (rhs_sel >= BITWIDTH'(BITWIDTH)) ? '0 : (lhs_sel << rhs_sel);
    rr_ptr_d       = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q <= '0;
      run_q    <= 1'b0;
    end else begin
      run_q <= 1'b1;
      if (accept) rr_ptr_q <= rr_ptr_d;
    end
  end

  // A stall freezes every stage, bubbles included, so issue order is preserved.
  generate
    for (genvar gi = 0; gi < LATENCY; gi++) begin : g_pipe
      if (gi == 0) begin : g_head
        always_ff @(posedge clk or negedge rst) begin
          if (!rst)        pipe_q[gi] <= '0;
          else if (!stall) pipe_q[gi] <= stage0_d;
        end
      end else begin : g_body
        always_ff @(posedge clk or negedge rst) begin
          if (!rst)        pipe_q[gi] <= '0;
          else if (!stall) pipe_q[gi] <= pipe_q[gi-1];
        end
      end
    end
  endgenerate

  assign result = tail.data;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rv
      assign result_valid[gi] = tail.valid & (tail.tag == TW'(gi));
    end
  endgenerate

`ifdef SHIFT_SHARE_STATS_EN
  logic [31:0] stall_cycles_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                  stall_cycles_q <= '0;
    else if (stall && (stall_cycles_q != '1)) stall_cycles_q <= stall_cycles_q + 32'd1;
  end

  assign stall_cycles = stall_cycles_q;
`endif

endmodule
